// File: rtl/pic_pkg.sv
// Shared types for the 8259 host-side driver: bus phases, bus-cycle kinds,
// controller states and the ICW1 bit positions that steer the config sequence.
package pic_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP} phase_t;
    typedef enum logic [1:0] {WRITE, READ, ACK1, ACK2} kind_t;
    typedef enum logic [2:0] {
        CTL_IDLE, CTL_ICW1, CTL_ICW2, CTL_ICW3, CTL_ICW4, CTL_ACK1, CTL_ACK2, CTL_REQ
    } ctl_t;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_D4   = 4;

    // Which ICW follows the one just written; CTL_IDLE means the sequence is complete.
    function automatic ctl_t next_icw(input ctl_t cur, input logic sngl, input logic ic4);
        next_icw = CTL_IDLE;
        case (cur)
            CTL_ICW1: next_icw = CTL_ICW2;
            CTL_ICW2: begin
                if (!sngl)
                    next_icw = CTL_ICW3;
                else if (ic4)
                    next_icw = CTL_ICW4;
            end
            CTL_ICW3: if (ic4) next_icw = CTL_ICW4;
            default:  next_icw = CTL_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/pic_bus_cycle.sv
// One 8259 bus cycle (write, read or INTA pulse). Every bus pin is a flop loaded
// from the next-phase decode, so strobes move exactly with the phase register.
module pic_bus_cycle
    import pic_pkg::*;
#(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  kind_t      kind,
    input  logic       a0,
    input  logic [7:0] data,
    input  logic [7:0] data_in,
    output logic       idle,
    output logic       done,
    output phase_t     phase,
    output logic       cs,
    output logic       wd,
    output logic       rd,
    output logic       inta,
    output logic       a0_bus,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       vector_valid,
    output logic [7:0] vector
);

    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

    phase_t     phase_q, phase_n;
    kind_t      kind_q, kind_n;
    logic [7:0] cnt_q, cnt_n;
    logic       a0_q, a0_n;
    logic [7:0] data_q, data_n;
    logic       bus_on, is_ack, is_wr, capture;

    always_comb begin
        phase_n = phase_q;
        cnt_n   = cnt_q;
        kind_n  = kind_q;
        a0_n    = a0_q;
        data_n  = data_q;
        case (phase_q)
            IDLE: begin
                if (start) begin
                    phase_n = SETUP;
                    kind_n  = kind;
                    a0_n    = a0;
                    data_n  = data;
                end
            end
            SETUP: begin
                phase_n = STROBE;
                cnt_n   = '0;
            end
            STROBE: begin
                if (cnt_q == PULSE_LAST)
                    phase_n = HOLD;
                else
                    cnt_n = cnt_q + 8'd1;
            end
            HOLD: begin
                phase_n = GAP;
                cnt_n   = '0;
            end
            GAP: begin
                if (cnt_q == GAP_LAST)
                    phase_n = IDLE;
                else
                    cnt_n = cnt_q + 8'd1;
            end
            default: phase_n = IDLE;
        endcase
    end

    assign bus_on  = (phase_n == SETUP) || (phase_n == STROBE) || (phase_n == HOLD);
    assign is_ack  = (kind_n == ACK1) || (kind_n == ACK2);
    assign is_wr   = (kind_n == WRITE);
    // The PIC drives the bus during the last strobe cycle; latch it on leaving STROBE.
    assign capture = (phase_q == STROBE) && (cnt_q == PULSE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= IDLE;
            cnt_q        <= '0;
            kind_q       <= WRITE;
            a0_q         <= 1'b0;
            data_q       <= '0;
            cs           <= 1'b1;
            wd           <= 1'b1;
            rd           <= 1'b1;
            inta         <= 1'b1;
            a0_bus       <= 1'b0;
            data_out     <= '0;
            data_oe      <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            vector_valid <= 1'b0;
            vector       <= '0;
        end else begin
            phase_q      <= phase_n;
            cnt_q        <= cnt_n;
            kind_q       <= kind_n;
            a0_q         <= a0_n;
            data_q       <= data_n;
            cs           <= !(bus_on && !is_ack);
            wd           <= !((phase_n == STROBE) && is_wr);
            rd           <= !((phase_n == STROBE) && (kind_n == READ));
            inta         <= !((phase_n == STROBE) && is_ack);
            a0_bus       <= (bus_on && !is_ack) ? a0_n : 1'b0;
            data_out     <= (bus_on && is_wr) ? data_n : 8'h00;
            data_oe      <= bus_on && is_wr;
            rd_valid     <= capture && (kind_q == READ);
            vector_valid <= capture && (kind_q == ACK2);
            if (capture && (kind_q == READ))
                rd_data <= data_in;
            if (capture && (kind_q == ACK2))
                vector <= data_in;
        end
    end

    assign idle  = (phase_q == IDLE);
    assign done  = (phase_q == GAP) && (cnt_q == GAP_LAST);
    assign phase = phase_q;

endmodule

// File: rtl/pic_host_driver.sv
// CPU-side master for the 8259: runs the ICW sequence, arbitrates INT acknowledge
// pairs against host OCW/status requests, and hands cycles to pic_bus_cycle.
module pic_host_driver
    import pic_pkg::*;
#(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_start,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    output logic       cfg_ready,
    output logic       cfg_done,
    input  logic       req_valid,
    input  logic       req_rd,
    input  logic       req_a0,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    input  logic       INT,
    output logic       vector_valid,
    output logic [7:0] vector,
    output logic       CS,
    output logic       WD,
    output logic       RD,
    output logic       INTA,
    output logic       A0,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in
);

    ctl_t       state_q, state_n, after;
    logic       sngl_q, ic4_q, sngl_n, ic4_n;
    logic [7:0] icw2_q, icw3_q, icw4_q;
    logic       eng_idle, eng_done;
    phase_t     eng_phase;
    logic       launch, launch_a0, arb, cfg_accept, cfg_more;
    kind_t      launch_kind;
    logic [7:0] launch_data;

    // Follow-on cycles (next ICW, ACK2) take priority; arbitration only runs once they are exhausted.
    always_comb begin
        state_n     = state_q;
        launch      = 1'b0;
        launch_kind = WRITE;
        launch_a0   = 1'b0;
        launch_data = 8'h00;
        arb         = 1'b0;
        cfg_accept  = 1'b0;
        req_ready   = 1'b0;
        after       = next_icw(state_q, sngl_q, ic4_q);
        if (eng_idle) begin
            if (state_q == CTL_ACK1) begin
                state_n     = CTL_ACK2;
                launch      = 1'b1;
                launch_kind = ACK2;
            end else if (after != CTL_IDLE) begin
                state_n   = after;
                launch    = 1'b1;
                launch_a0 = 1'b1;
                case (after)
                    CTL_ICW2: launch_data = icw2_q;
                    CTL_ICW3: launch_data = icw3_q;
                    default:  launch_data = icw4_q;
                endcase
            end else begin
                arb = 1'b1;
            end
        end
        if (arb) begin
            if (cfg_start && cfg_ready) begin
                cfg_accept  = 1'b1;
                state_n     = CTL_ICW1;
                launch      = 1'b1;
                launch_data = icw1 | (8'h01 << ICW1_D4);
            end else if (INT && cfg_done) begin
                state_n     = CTL_ACK1;
                launch      = 1'b1;
                launch_kind = ACK1;
            end else if (req_valid) begin
                req_ready   = 1'b1;
                state_n     = CTL_REQ;
                launch      = 1'b1;
                launch_kind = req_rd ? READ : WRITE;
                launch_a0   = req_a0;
                launch_data = req_data;
            end else begin
                state_n = CTL_IDLE;
            end
        end
    end

    assign sngl_n   = cfg_accept ? icw1[ICW1_SNGL] : sngl_q;
    assign ic4_n    = cfg_accept ? icw1[ICW1_IC4]  : ic4_q;
    // cfg_ready is a flop, so predict next cycle: engine idle and no forced follow-on cycle.
    assign cfg_more = (state_n == CTL_ACK1) || (next_icw(state_n, sngl_n, ic4_n) != CTL_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CTL_IDLE;
            sngl_q    <= 1'b0;
            ic4_q     <= 1'b0;
            icw2_q    <= '0;
            icw3_q    <= '0;
            icw4_q    <= '0;
            cfg_done  <= 1'b0;
            cfg_ready <= 1'b0;
        end else begin
            state_q   <= state_n;
            sngl_q    <= sngl_n;
            ic4_q     <= ic4_n;
            cfg_ready <= (eng_done || (eng_idle && !launch)) && !cfg_more;
            if (cfg_accept) begin
                icw2_q   <= icw2;
                icw3_q   <= icw3;
                icw4_q   <= icw4;
                cfg_done <= 1'b0;
            end else if ((eng_phase == HOLD) &&
                         (state_q inside {CTL_ICW2, CTL_ICW3, CTL_ICW4}) &&
                         (next_icw(state_q, sngl_q, ic4_q) == CTL_IDLE)) begin
                cfg_done <= 1'b1;
            end
        end
    end

    pic_bus_cycle #(
        .PULSE_CYCLES(PULSE_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES)
    ) u_bus (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (launch),
        .kind        (launch_kind),
        .a0          (launch_a0),
        .data        (launch_data),
        .data_in     (data_in),
        .idle        (eng_idle),
        .done        (eng_done),
        .phase       (eng_phase),
        .cs          (CS),
        .wd          (WD),
        .rd          (RD),
        .inta        (INTA),
        .a0_bus      (A0),
        .data_out    (data_out),
        .data_oe     (data_oe),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .vector_valid(vector_valid),
        .vector      (vector)
    );

endmodule

// File: tb/tb_pic_host_driver.sv
// Bench for pic_host_driver: a table of ICW configurations plus hand-written
// ACK, arbitration, read and mid-cycle reset sequences, checked via scoreboards.
module tb_pic_host_driver;

    localparam int PULSE = 2;
    localparam int GAP   = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_start;
    logic [7:0] icw1, icw2, icw3, icw4;
    logic       cfg_ready, cfg_done;
    logic       req_valid, req_rd, req_a0;
    logic [7:0] req_data;
    logic       req_ready, rd_valid;
    logic [7:0] rd_data;
    logic       INT;
    logic       vector_valid;
    logic [7:0] vector;
    logic       CS, WD, RD, INTA, A0;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] data_in;

    always #5 clk = ~clk;

    pic_host_driver #(.PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
        .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
        .cfg_ready(cfg_ready), .cfg_done(cfg_done),
        .req_valid(req_valid), .req_rd(req_rd), .req_a0(req_a0), .req_data(req_data),
        .req_ready(req_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .INT(INT), .vector_valid(vector_valid), .vector(vector),
        .CS(CS), .WD(WD), .RD(RD), .INTA(INTA), .A0(A0),
        .data_out(data_out), .data_oe(data_oe), .data_in(data_in)
    );

    typedef struct {
        logic [7:0] icw1, icw2, icw3, icw4;
        int         exp_writes;
        logic [7:0] exp_icw1_bus;
    } cfg_vec_t;

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [8:0] wr_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] vec_q[$];
    int         writes_seen = 0;
    int         inta_total = 0;
    logic       rd_a0_exp = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flagFail(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s", name);
    endtask

    // Bus monitor: pops scoreboards on strobes and valid pulses, checks pulse shape.
    initial begin
        logic wd_prev = 1'b1, rd_prev = 1'b1, inta_prev = 1'b1, vv_prev = 1'b0;
        int   wd_len = 0, rd_len = 0, inta_len = 0, pair_cnt = 0, first_inta = 0, cyc = 0;
        logic [8:0] exp_wr;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                wd_prev = 1'b1; rd_prev = 1'b1; inta_prev = 1'b1; vv_prev = 1'b0;
                wd_len = 0; rd_len = 0; inta_len = 0; pair_cnt = 0;
                continue;
            end
            if (rd_valid) begin
                if (rd_q.size() == 0) flagFail("unexpected rd_valid");
                else checkOutput("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
                checkOutput("rd_valid in HOLD", 32'({rd_prev, RD, CS}), 32'(3'b010));
            end
            if (vv_prev)
                checkOutput("vector_valid width", 32'(vector_valid), 0);
            if (vector_valid) begin
                if (vec_q.size() == 0) flagFail("unexpected vector_valid");
                else checkOutput("vector", 32'(vector), 32'(vec_q.pop_front()));
                checkOutput("INTA pulses per vector", 32'(pair_cnt), 2);
                checkOutput("vector timing", 32'(cyc - first_inta), 8);
                checkOutput("vector_valid in HOLD", 32'({inta_prev, INTA}), 32'(2'b01));
                pair_cnt = 0;
            end
            vv_prev = vector_valid;
            if (!WD) begin
                if (wd_prev) begin
                    writes_seen++;
                    if (wr_q.size() == 0) flagFail("unexpected write");
                    else begin
                        exp_wr = wr_q.pop_front();
                        checkOutput("write A0/data", 32'({A0, data_out}), 32'(exp_wr));
                    end
                    checkOutput("write CS/oe", 32'({CS, data_oe}), 32'(2'b01));
                end
                wd_len++;
            end else if (!wd_prev) begin
                checkOutput("WD width", 32'(wd_len), PULSE);
                wd_len = 0;
            end
            if (!RD) begin
                if (rd_prev)
                    checkOutput("read CS/A0/oe", 32'({CS, A0, data_oe}), 32'({1'b0, rd_a0_exp, 1'b0}));
                rd_len++;
            end else if (!rd_prev) begin
                checkOutput("RD width", 32'(rd_len), PULSE);
                rd_len = 0;
            end
            if (!INTA) begin
                if (inta_prev) begin
                    inta_total++;
                    if (pair_cnt == 0) first_inta = cyc;
                    pair_cnt++;
                end
                checkOutput("INTA CS/oe", 32'({CS, data_oe}), 32'(2'b10));
                inta_len++;
            end else if (!inta_prev) begin
                checkOutput("INTA width", 32'(inta_len), PULSE);
                inta_len = 0;
            end
            wd_prev = WD; rd_prev = RD; inta_prev = INTA;
        end
    end

    task automatic waitCfgReady();
        int n = 0;
        while (!cfg_ready && n < 100) begin @(negedge clk); n++; end
        checkOutput("cfg_ready", 32'(cfg_ready), 1);
    endtask

    task automatic pushConfig(input cfg_vec_t v);
        wr_q.push_back({1'b0, v.exp_icw1_bus});
        wr_q.push_back({1'b1, v.icw2});
        if (!v.icw1[1]) wr_q.push_back({1'b1, v.icw3});
        if (v.icw1[0])  wr_q.push_back({1'b1, v.icw4});
        icw1 = v.icw1; icw2 = v.icw2; icw3 = v.icw3; icw4 = v.icw4;
    endtask

    task automatic applyStimulus(input cfg_vec_t v);
        int n;
        waitCfgReady();
        pushConfig(v);
        writes_seen = 0;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        checkOutput("cfg_done cleared on start", 32'({cfg_done, cfg_ready}), 0);
        n = 1;
        while (!cfg_done && n < 200) begin @(negedge clk); n++; end
        checkOutput("cfg_done set", 32'(cfg_done), 1);
        checkOutput("config cycles", 32'(n), 32'(6 * v.exp_writes - 1));
        checkOutput("cfg_done in GAP", 32'({CS, WD, data_oe}), 32'(3'b110));
        repeat (2) @(negedge clk);
        checkOutput("write count", 32'(writes_seen), 32'(v.exp_writes));
        checkOutput("write queue drained", 32'(wr_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        cfg_vec_t vecs[4];
        int n;
        logic seen_low;
        vecs[0] = '{icw1: 8'h13, icw2: 8'h40, icw3: 8'h00, icw4: 8'h01, exp_writes: 3, exp_icw1_bus: 8'h13};
        vecs[1] = '{icw1: 8'h01, icw2: 8'h08, icw3: 8'h04, icw4: 8'h01, exp_writes: 4, exp_icw1_bus: 8'h11};
        vecs[2] = '{icw1: 8'h12, icw2: 8'h50, icw3: 8'h00, icw4: 8'h00, exp_writes: 2, exp_icw1_bus: 8'h12};
        vecs[3] = '{icw1: 8'h00, icw2: 8'h60, icw3: 8'h02, icw4: 8'h00, exp_writes: 3, exp_icw1_bus: 8'h10};

        rst_n = 1'b0; cfg_start = 1'b0; icw1 = '0; icw2 = '0; icw3 = '0; icw4 = '0;
        req_valid = 1'b0; req_rd = 1'b0; req_a0 = 1'b0; req_data = '0; INT = 1'b0; data_in = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset strobes", 32'({CS, WD, RD, INTA}), 32'(4'hF));
        checkOutput("reset A0/data/oe", 32'({A0, data_out, data_oe}), 0);
        checkOutput("reset status", 32'({cfg_done, cfg_ready, req_ready, rd_valid, vector_valid}), 0);
        checkOutput("reset captures", 32'({rd_data, vector}), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("cfg_ready before first clock", 32'(cfg_ready), 0);
        @(negedge clk);
        checkOutput("cfg_ready after first clock", 32'(cfg_ready), 1);

        INT = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("INT ignored before config", 32'(inta_total), 0);
        INT = 1'b0;

        for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

        // Plain ACK pair; vector only becomes valid on the bus during ACK2.
        waitCfgReady();
        data_in = 8'h99;
        vec_q.push_back(8'h42);
        INT = 1'b1;
        seen_low = 1'b0;
        n = 0;
        while (vec_q.size() != 0 && n < 100) begin
            @(negedge clk); n++;
            if (!INTA) begin INT = 1'b0; seen_low = 1'b1; end
            else if (seen_low) data_in = 8'h42;
        end
        checkOutput("ACK pair delivered vector", 32'(vec_q.size()), 0);
        checkOutput("vector register", 32'(vector), 32'h42);

        // INT and an OCW1 write arrive together: the ACK pair wins.
        waitCfgReady();
        vec_q.push_back(8'h42);
        wr_q.push_back({1'b1, 8'hFB});
        writes_seen = 0;
        INT = 1'b1; req_valid = 1'b1; req_rd = 1'b0; req_a0 = 1'b1; req_data = 8'hFB;
        n = 0;
        #1;
        while (!req_ready && n < 100) begin
            @(negedge clk); n++;
            if (!INTA) INT = 1'b0;
        end
        checkOutput("req_ready after ACK pair", 32'(n), 12);
        checkOutput("vector before OCW write", 32'(vec_q.size()), 0);
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("OCW write issued", 32'(writes_seen), 1);
        checkOutput("OCW queue drained", 32'(wr_q.size()), 0);

        // Status read with A0=0.
        waitCfgReady();
        data_in = 8'hA5; rd_a0_exp = 1'b0;
        rd_q.push_back(8'hA5);
        req_valid = 1'b1; req_rd = 1'b1; req_a0 = 1'b0;
        #1;
        checkOutput("read accepted in IDLE", 32'(req_ready), 1);
        @(posedge clk); #1 req_valid = 1'b0; req_rd = 1'b0;
        n = 0;
        while (rd_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
        checkOutput("read delivered", 32'(rd_q.size()), 0);
        data_in = 8'h00;

        // Reset lands in ICW2's WD strobe; a fresh start must begin again at ICW1.
        waitCfgReady();
        pushConfig(vecs[0]);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        n = 0;
        while (!(!WD && A0) && n < 50) begin @(negedge clk); n++; end
        checkOutput("ICW2 strobe reached", 32'({WD, A0}), 32'(2'b01));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset strobes", 32'({WD, CS, data_oe, cfg_done}), 32'(4'b1100));
        wr_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        applyStimulus(vecs[0]);

        repeat (5) @(negedge clk);
        checkOutput("scoreboards empty", 32'(wr_q.size() + rd_q.size() + vec_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
